bcd_quiz_engine: RTL



---
 rtl/bcd_quiz_engine.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_quiz_engine.sv
// Multi-round BCD quiz: a debounced button steps an FSM that shows a pseudo-random
// target (hex or decimal) and a saturating decimal score on a scanned 7-segment display.
module bcd_quiz_engine #(
  parameter int SW_W         = 5,
  parameter int DIGITS       = 4,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int REFRESH_CYC  = 100000,
  parameter int RESULT_CYC   = 50000000,
  parameter int ROUNDS       = 10
) (
  input  logic              CLK,
  input  logic              R,
  input  logic              BTN,
  input  logic [SW_W-1:0]   SW,
  output logic [6:0]        cathode,
  output logic [DIGITS-1:0] anode,
  output logic              HEX,
  output logic              DEC,
  output logic              HIT,
  output logic              MISS,
  output logic              DONE
);
  localparam int TN  = DIGITS - 2;
  localparam int TW  = 4 * TN;
  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int RFW = $clog2(REFRESH_CYC + 1);
  localparam int RSW = $clog2(RESULT_CYC + 1);
  localparam int RDW = $clog2(ROUNDS + 1);
  localparam int CVW = $clog2(SW_W + 1);
  localparam int IW  = $clog2(DIGITS);

  typedef enum logic [2:0] {IDLE, NEW, CONV, SHOW, JUDGE, RESULT, DONEST} state_t;
  state_t state, next;

  logic           sync1, sync2, db, db_d, press;
  logic [DBW-1:0] db_cnt;
  logic [15:0]    lfsr;

  logic [SW_W-1:0]      tgt, tsh;
  logic [TW-1:0]        work, adj, work_nx;
  logic [TN-1:0][3:0]   disp;
  logic                 tgt_valid, hit_flag;
  logic [CVW-1:0]       conv_cnt;
  logic [RSW-1:0]       res_cnt;
  logic [RDW-1:0]       round;
  logic [3:0]           score_t, score_o;

  logic                 scan_on;
  logic [RFW-1:0]       rf_cnt;
  logic [IW-1:0]        idx;
  logic [TN-1:0]        lit;
  logic                 any;

  // Button: level is accepted only after DEBOUNCE_CYC consecutive differing samples
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db     <= 1'b0;
      db_d   <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= BTN;
      sync2 <= sync1;
      db_d  <= db;
      if (sync2 == db)
        db_cnt <= '0;
      else if (db_cnt == DBW'(DEBOUNCE_CYC - 1)) begin
        db     <= sync2;
        db_cnt <= '0;
      end else
        db_cnt <= db_cnt + 1'b1;
    end
  end

  assign press = db & ~db_d;

  always_ff @(posedge CLK or negedge R) begin
    if (!R) lfsr <= 16'hACE1;
    else    lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) state <= IDLE;
    else    state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (press) next = NEW;
      NEW:     next = CONV;
      CONV:    if (conv_cnt == CVW'(SW_W - 1)) next = SHOW;
      SHOW:    if (press) next = JUDGE;
      JUDGE:   next = RESULT;
      RESULT:  if (res_cnt == RSW'(RESULT_CYC - 1))
                 next = (round == RDW'(ROUNDS)) ? DONEST : NEW;
      DONEST:  if (press) next = NEW;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    HIT  = (state == RESULT) &  hit_flag;
    MISS = (state == RESULT) & ~hit_flag;
    DONE = (state == DONEST);
  end

  // Double-dabble step; in hex mode skipping the add-3 leaves plain binary nibbles
  always_comb begin
    adj = work;
    if (!HEX)
      for (int i = 0; i < TN; i++)
        if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    work_nx = {adj[TW-2:0], tsh[SW_W-1]};
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      tgt       <= '0;
      tsh       <= '0;
      work      <= '0;
      disp      <= '0;
      tgt_valid <= 1'b0;
      hit_flag  <= 1'b0;
      HEX       <= 1'b0;
      DEC       <= 1'b0;
      conv_cnt  <= '0;
      res_cnt   <= '0;
      round     <= '0;
      score_t   <= '0;
      score_o   <= '0;
    end else begin
      case (state)
        NEW: begin
          tgt      <= lfsr[SW_W-1:0];
          tsh      <= lfsr[SW_W-1:0];
          work     <= '0;
          HEX      <= lfsr[15];
          DEC      <= ~lfsr[15];
          conv_cnt <= '0;
        end
        CONV: begin
          tsh      <= tsh << 1;
          work     <= work_nx;
          conv_cnt <= conv_cnt + 1'b1;
          if (conv_cnt == CVW'(SW_W - 1)) begin
            disp      <= work_nx;
            tgt_valid <= 1'b1;
          end
        end
        JUDGE: begin
          hit_flag <= (SW == tgt);
          round    <= round + 1'b1;
          res_cnt  <= '0;
          if (SW == tgt) begin
            if (score_o != 4'd9)
              score_o <= score_o + 4'd1;
            else if (score_t != 4'd9) begin
              score_o <= 4'd0;
              score_t <= score_t + 4'd1;
            end
          end
        end
        RESULT: res_cnt <= res_cnt + 1'b1;
        DONEST: if (press) begin
          round   <= '0;
          score_t <= '0;
          score_o <= '0;
        end
        default: ;
      endcase
    end
  end

  // Scan starts on the first edge after reset release
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      scan_on <= 1'b0;
      rf_cnt  <= '0;
      idx     <= '0;
    end else begin
      scan_on <= 1'b1;
      if (scan_on) begin
        if (rf_cnt == RFW'(REFRESH_CYC - 1)) begin
          rf_cnt <= '0;
          idx    <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else
          rf_cnt <= rf_cnt + 1'b1;
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  // Leading-zero blanking on the target field; the lowest target digit is always lit
  always_comb begin
    any = 1'b0;
    lit = '0;
    for (int i = TN - 1; i >= 0; i--) begin
      any    = any | (disp[i] != 4'd0);
      lit[i] = any | (i == 0);
    end
  end

  always_comb begin
    anode   = '1;
    cathode = 7'h7F;
    if (scan_on) begin
      anode = ~(DIGITS'(1) << idx);
      if (state == IDLE)         cathode = 7'h3F;
      else if (idx == '0)        cathode = seg7(score_o);
      else if (idx == IW'(1))    cathode = seg7(score_t);
      else if (state == DONEST)  cathode = 7'h7F;
      else if (!tgt_valid)       cathode = 7'h3F;
      else
        for (int i = 0; i < TN; i++)
          if (idx == IW'(i + 2)) cathode = lit[i] ? seg7(disp[i]) : 7'h7F;
    end
  end
endmodule
